// File: rtl/decode_stage.sv
// MIPS decode stage: register file with write-first bypass, control decode,
// load-use/branch hazard stall, in-decode branch resolution and the ID/EX register.
module decode_stage #(
    parameter int unsigned NREGS    = 32,
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [31:0] pc_in,
    input  logic [31:0] instr_in,
    input  logic        wb_en,
    input  logic [4:0]  wb_rd,
    input  logic [31:0] wb_val,
    input  logic [4:0]  mem_load_rd,
    output logic        stall_f,
    output logic        branch_taken,
    output logic [31:0] branch_target,
    output logic        ex_valid,
    output logic [31:0] ex_pc,
    output logic [31:0] ex_rs_val,
    output logic [31:0] ex_rt_val,
    output logic [31:0] ex_imm,
    output logic [4:0]  ex_rd,
    output logic [2:0]  ex_alu_op,
    output logic        ex_alu_imm,
    output logic        ex_reg_write,
    output logic        ex_mem_read,
    output logic        ex_mem_write
);
    localparam int unsigned XLEN = 32;
    localparam int unsigned RW   = 5;
    localparam int unsigned AW   = 3;

    typedef struct packed {
        logic            valid;
        logic [XLEN-1:0] pc;
        logic [XLEN-1:0] rs_val;
        logic [XLEN-1:0] rt_val;
        logic [XLEN-1:0] imm;
        logic [RW-1:0]   rd;
        logic [AW-1:0]   alu_op;
        logic            alu_imm;
        logic            reg_write;
        logic            mem_read;
        logic            mem_write;
    } idex_t;

    logic [XLEN-1:0] rf_q [NREGS];
    logic [XLEN-1:0] rf_d [NREGS];
    idex_t           ex_q, ex_d;
    logic            in_valid_q, in_valid_d;

    logic [5:0]      op, funct;
    logic [RW-1:0]   rs, rt, rd, dest;
    logic [XLEN-1:0] imm_s, imm_ext, rs_val, rt_val, pc_plus4;
    logic [AW-1:0]   alu_op;
    logic            dec_valid, alu_imm, mem_rd, mem_wr;
    logic            is_beq, is_bne, is_j, uses_rs, uses_rt;
    logic            load_use, br_hazard, taken, stall;

    assign op    = instr_in[31:26];
    assign rs    = instr_in[25:21];
    assign rt    = instr_in[20:16];
    assign rd    = instr_in[15:11];
    assign funct = instr_in[5:0];
    assign imm_s = {{16{instr_in[15]}}, instr_in[15:0]};

    // Register file next state; r0 is never written.
    always_comb begin
        rf_d = rf_q;
        if (wb_en && wb_rd != RW'(0)) begin
            rf_d[wb_rd] = wb_val;
        end
    end

    // Combinational reads with write-first bypass of the writeback port.
    always_comb begin
        rs_val = '0;
        rt_val = '0;
        if (rs != RW'(0)) begin
            rs_val = (wb_en && wb_rd == rs) ? wb_val : rf_q[rs];
        end
        if (rt != RW'(0)) begin
            rt_val = (wb_en && wb_rd == rt) ? wb_val : rf_q[rt];
        end
    end

    // Instruction decode; anything unrecognised stays a bubble.
    always_comb begin
        dec_valid = 1'b0;
        alu_op    = AW'(0);
        alu_imm   = 1'b0;
        dest      = RW'(0);
        mem_rd    = 1'b0;
        mem_wr    = 1'b0;
        is_beq    = 1'b0;
        is_bne    = 1'b0;
        is_j      = 1'b0;
        uses_rs   = 1'b1;
        uses_rt   = 1'b0;
        imm_ext   = imm_s;
        case (op)
            6'h00: begin
                dec_valid = 1'b1;
                uses_rt   = 1'b1;
                dest      = rd;
                case (funct)
                    6'h21:   alu_op = AW'(0);
                    6'h23:   alu_op = AW'(1);
                    6'h24:   alu_op = AW'(2);
                    6'h25:   alu_op = AW'(3);
                    6'h2A:   alu_op = AW'(4);
                    default: dec_valid = 1'b0;
                endcase
            end
            6'h09: begin
                dec_valid = 1'b1;
                alu_imm   = 1'b1;
                dest      = rt;
            end
            6'h0C: begin
                dec_valid = 1'b1;
                alu_imm   = 1'b1;
                alu_op    = AW'(2);
                dest      = rt;
                imm_ext   = {16'h0000, instr_in[15:0]};
            end
            6'h0D: begin
                dec_valid = 1'b1;
                alu_imm   = 1'b1;
                alu_op    = AW'(3);
                dest      = rt;
                imm_ext   = {16'h0000, instr_in[15:0]};
            end
            6'h0F: begin
                dec_valid = 1'b1;
                alu_imm   = 1'b1;
                alu_op    = AW'(5);
                dest      = rt;
                uses_rs   = 1'b0;
                imm_ext   = {instr_in[15:0], 16'h0000};
            end
            6'h23: begin
                dec_valid = 1'b1;
                alu_imm   = 1'b1;
                dest      = rt;
                mem_rd    = 1'b1;
            end
            6'h2B: begin
                dec_valid = 1'b1;
                alu_imm   = 1'b1;
                mem_wr    = 1'b1;
                uses_rt   = 1'b1;
            end
            6'h04: begin
                dec_valid = 1'b1;
                is_beq    = 1'b1;
                uses_rt   = 1'b1;
            end
            6'h05: begin
                dec_valid = 1'b1;
                is_bne    = 1'b1;
                uses_rt   = 1'b1;
            end
            6'h02: begin
                dec_valid = 1'b1;
                is_j      = 1'b1;
                uses_rs   = 1'b0;
            end
            default: dec_valid = 1'b0;
        endcase
    end

    // Hazards: load result not yet available, or branch operands still in flight.
    always_comb begin
        load_use  = dec_valid && ex_q.mem_read && ex_q.rd != RW'(0) &&
                    ((uses_rs && rs == ex_q.rd) || (uses_rt && rt == ex_q.rd));
        br_hazard = (is_beq || is_bne) && dec_valid &&
                    ((ex_q.reg_write && (rs == ex_q.rd || rt == ex_q.rd)) ||
                     (mem_load_rd != RW'(0) && (rs == mem_load_rd || rt == mem_load_rd)));
        stall     = in_valid_q && (load_use || br_hazard);
    end

    // Branch/jump resolution and redirect address.
    always_comb begin
        pc_plus4      = pc_in + 32'd4;
        taken         = dec_valid && ((is_beq && rs_val == rt_val) ||
                                      (is_bne && rs_val != rt_val) || is_j);
        branch_target = is_j ? {pc_plus4[31:28], instr_in[25:0], 2'b00}
                             : pc_plus4 + (imm_s << 2);
        branch_taken  = in_valid_q && !stall && taken;
        stall_f       = stall;
    end

    // ID/EX next state; a stall or invalid slot injects a bubble.
    always_comb begin
        in_valid_d = 1'b1;
        ex_d       = '0;
        ex_d.pc    = pc_in;
        ex_d.rs_val = rs_val;
        ex_d.rt_val = rt_val;
        ex_d.imm   = imm_ext;
        if (in_valid_q && !stall && dec_valid) begin
            ex_d.valid     = 1'b1;
            ex_d.rd        = dest;
            ex_d.alu_op    = alu_op;
            ex_d.alu_imm   = alu_imm;
            ex_d.reg_write = (dest != RW'(0));
            ex_d.mem_read  = mem_rd;
            ex_d.mem_write = mem_wr;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int unsigned i = 0; i < NREGS; i++) begin
                rf_q[i] <= '0;
            end
            ex_q       <= '0;
            ex_q.pc    <= RESET_PC;
            in_valid_q <= 1'b0;
        end else begin
            rf_q       <= rf_d;
            ex_q       <= ex_d;
            in_valid_q <= in_valid_d;
        end
    end

    assign ex_valid     = ex_q.valid;
    assign ex_pc        = ex_q.pc;
    assign ex_rs_val    = ex_q.rs_val;
    assign ex_rt_val    = ex_q.rt_val;
    assign ex_imm       = ex_q.imm;
    assign ex_rd        = ex_q.rd;
    assign ex_alu_op    = ex_q.alu_op;
    assign ex_alu_imm   = ex_q.alu_imm;
    assign ex_reg_write = ex_q.reg_write;
    assign ex_mem_read  = ex_q.mem_read;
    assign ex_mem_write = ex_q.mem_write;
endmodule
